// File: rtl/cache_refill_ctrl_pkg.sv
// Shared parameters, types and helpers for the cache miss-refill controller.
package cache_pkg;

  localparam int TAG_W    = 8;
  localparam int NUM_SETS = 26;
  localparam int NUM_WAYS = 5;
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int WAY_W    = $clog2(NUM_WAYS);

  typedef logic [SET_W-1:0] set_t;
  typedef logic [WAY_W-1:0] way_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    FILL = 3'd3,
    RESP = 3'd4
  } refill_state_e;

  // Set count need not be a power of two, so an index can name a non-existent row.
  function automatic logic set_ok(set_t s);
    return {1'b0, s} < (SET_W+1)'(NUM_SETS);
  endfunction

  function automatic way_t next_way(way_t w);
    return (w == way_t'(NUM_WAYS-1)) ? '0 : w + 1'b1;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Lookup, memory-fetch, tag-write and response signals of the refill controller.
interface cache_refill_ctrl_if;
  import cache_pkg::*;

  logic lk_valid;
  logic lk_ready;
  logic lk_hit;
  way_t lk_way;
  set_t lk_index;
  tag_t lk_tag;

  logic mem_req_valid;
  logic mem_req_ready;
  set_t mem_req_index;
  tag_t mem_req_tag;
  logic mem_rsp_valid;
  logic mem_rsp_err;

  logic tag_we;
  set_t tag_wr_index;
  way_t tag_wr_way;
  tag_t tag_wr_data;

  logic resp_valid;
  logic resp_hit;
  way_t resp_way;
  logic resp_err;

  modport master (
    input  lk_valid, lk_hit, lk_way, lk_index, lk_tag,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_err,
    output lk_ready,
    output mem_req_valid, mem_req_index, mem_req_tag,
    output tag_we, tag_wr_index, tag_wr_way, tag_wr_data,
    output resp_valid, resp_hit, resp_way, resp_err
  );

  modport slave (
    output lk_valid, lk_hit, lk_way, lk_index, lk_tag,
    output mem_req_ready, mem_rsp_valid, mem_rsp_err,
    input  lk_ready,
    input  mem_req_valid, mem_req_index, mem_req_tag,
    input  tag_we, tag_wr_index, tag_wr_way, tag_wr_data,
    input  resp_valid, resp_hit, resp_way, resp_err
  );

endinterface

// File: rtl/cache_refill_ctrl_rr_victim_sel.sv
// Per-set round-robin victim pointers: combinational read, strobed advance with wrap.
module rr_victim_sel
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  set_t rd_set,
  output way_t rd_way,
  input  set_t adv_set,
  input  logic adv_en
);

  way_t ptr_q [NUM_SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
    end else if (adv_en && set_ok(adv_set)) begin
      ptr_q[adv_set] <= next_way(ptr_q[adv_set]);
    end
  end

  assign rd_way = set_ok(rd_set) ? ptr_q[rd_set] : '0;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling stage after tag lookup: acks hits, refills misses into a round-robin victim.
// Optional CACHE_STATS_EN adds saturating hit/miss counters as extra output ports.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  cache_refill_ctrl_if.master  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  // state | meaning
  // IDLE  | ready for a lookup result
  // REQ   | memory fetch request held until accepted
  // WAIT  | waiting for the fetch response
  // FILL  | one-cycle tag write into the victim way
  // RESP  | one-cycle completion pulse
  localparam logic [2:0] ST_IDLE = 3'(IDLE);
  localparam logic [2:0] ST_REQ  = 3'(REQ);
  localparam logic [2:0] ST_WAIT = 3'(WAIT);
  localparam logic [2:0] ST_FILL = 3'(FILL);
  localparam logic [2:0] ST_RESP = 3'(RESP);

  logic [2:0] state_q, state_d;
  set_t       index_q;
  tag_t       tag_q;
  logic       hit_q;
  logic       err_q;
  way_t       way_q;
  way_t       victim;
  logic       accept;
  logic       idx_ok;

  assign accept = (state_q == ST_IDLE) && bus.lk_valid;
  assign idx_ok = set_ok(bus.lk_index);

  rr_victim_sel u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_set  (bus.lk_index),
    .rd_way  (victim),
    .adv_set (index_q),
    .adv_en  (state_q == ST_FILL)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.lk_valid) state_d = (!idx_ok || bus.lk_hit) ? ST_RESP : ST_REQ;
      ST_REQ:  if (bus.mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (bus.mem_rsp_valid) state_d = bus.mem_rsp_err ? ST_RESP : ST_FILL;
      ST_FILL: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The victim is captured at accept; pointers only move in FILL, so it cannot go stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      tag_q   <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      way_q   <= '0;
    end else if (accept) begin
      index_q <= bus.lk_index;
      tag_q   <= bus.lk_tag;
      hit_q   <= idx_ok && bus.lk_hit;
      err_q   <= !idx_ok;
      way_q   <= !idx_ok ? '0 : (bus.lk_hit ? bus.lk_way : victim);
    end else if (state_q == ST_WAIT && bus.mem_rsp_valid && bus.mem_rsp_err) begin
      err_q   <= 1'b1;
    end
  end

  assign bus.lk_ready      = (state_q == ST_IDLE);
  assign bus.mem_req_valid = (state_q == ST_REQ);
  assign bus.mem_req_index = index_q;
  assign bus.mem_req_tag   = tag_q;
  assign bus.tag_we        = (state_q == ST_FILL);
  assign bus.tag_wr_index  = index_q;
  assign bus.tag_wr_way    = way_q;
  assign bus.tag_wr_data   = tag_q;
  assign bus.resp_valid    = (state_q == ST_RESP);
  assign bus.resp_hit      = hit_q;
  assign bus.resp_way      = way_q;
  assign bus.resp_err      = err_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (accept) begin
      if (bus.lk_hit && hit_count_q != 16'hFFFF)
        hit_count_q <= hit_count_q + 16'd1;
      if (!bus.lk_hit && idx_ok && miss_count_q != 16'hFFFF)
        miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl (hits, refills, stalls, errors, reset).
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_refill_ctrl_if bus();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_refill_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int tag_we_cnt  = 0;
  int mem_req_cnt = 0;
  int resp_cnt    = 0;

  always @(negedge clk) begin
    if (bus.tag_we)        tag_we_cnt++;
    if (bus.mem_req_valid) mem_req_cnt++;
    if (bus.resp_valid)    resp_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic lookup(input logic hit, input way_t way, input set_t idx, input tag_t tag);
    @(negedge clk);
    check_val("lk_ready_idle", 32'(bus.lk_ready), 32'd1);
    bus.lk_valid = 1'b1;
    bus.lk_hit   = hit;
    bus.lk_way   = way;
    bus.lk_index = idx;
    bus.lk_tag   = tag;
    @(negedge clk);
    bus.lk_valid = 1'b0;
    bus.lk_hit   = 1'b0;
  endtask

  task automatic do_hit(input way_t way, input set_t idx);
    int m0, t0;
    m0 = mem_req_cnt;
    t0 = tag_we_cnt;
    lookup(1'b1, way, idx, 8'h5A);
    check_val("hit_resp_valid", 32'(bus.resp_valid), 32'd1);
    check_val("hit_resp_hit",   32'(bus.resp_hit),   32'd1);
    check_val("hit_resp_way",   32'(bus.resp_way),   32'(way));
    check_val("hit_resp_err",   32'(bus.resp_err),   32'd0);
    @(negedge clk);
    check_val("hit_resp_pulse", 32'(bus.resp_valid), 32'd0);
    #1;
    check_val("hit_no_memreq", 32'(mem_req_cnt), 32'(m0));
    check_val("hit_no_tagwe",  32'(tag_we_cnt),  32'(t0));
  endtask

  task automatic do_miss(input set_t idx, input tag_t tag, input int rdy_delay,
                         input logic err, input way_t exp_way);
    int t0;
    t0 = tag_we_cnt;
    lookup(1'b0, 3'd7, idx, tag);
    for (int i = 0; i < rdy_delay; i++) begin
      check_val("stall_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check_val("stall_req_index", 32'(bus.mem_req_index), 32'(idx));
      check_val("stall_req_tag",   32'(bus.mem_req_tag),   32'(tag));
      check_val("stall_lk_ready",  32'(bus.lk_ready),      32'd0);
      @(negedge clk);
    end
    check_val("req_valid", 32'(bus.mem_req_valid), 32'd1);
    check_val("req_index", 32'(bus.mem_req_index), 32'(idx));
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check_val("wait_req_dropped", 32'(bus.mem_req_valid), 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_err   = err;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
    if (!err) begin
      check_val("fill_tag_we",   32'(bus.tag_we),       32'd1);
      check_val("fill_way",      32'(bus.tag_wr_way),   32'(exp_way));
      check_val("fill_data",     32'(bus.tag_wr_data),  32'(tag));
      check_val("fill_index",    32'(bus.tag_wr_index), 32'(idx));
      @(negedge clk);
    end
    check_val("miss_resp_valid", 32'(bus.resp_valid), 32'd1);
    check_val("miss_resp_err",   32'(bus.resp_err),   32'(err));
    check_val("miss_resp_hit",   32'(bus.resp_hit),   32'd0);
    if (!err) check_val("miss_resp_way", 32'(bus.resp_way), 32'(exp_way));
    @(negedge clk);
    check_val("miss_resp_pulse", 32'(bus.resp_valid), 32'd0);
    #1;
    check_val("miss_tagwe_count", 32'(tag_we_cnt), 32'(t0 + (err ? 0 : 1)));
  endtask

  initial begin
    int m0, t0, r0;
    bus.lk_valid = 1'b0;
    bus.lk_hit = 1'b0;
    bus.lk_way = '0;
    bus.lk_index = '0;
    bus.lk_tag = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_lk_ready",   32'(bus.lk_ready),      32'd1);
    check_val("rst_req_valid",  32'(bus.mem_req_valid), 32'd0);
    check_val("rst_tag_we",     32'(bus.tag_we),        32'd0);
    check_val("rst_resp_valid", 32'(bus.resp_valid),    32'd0);
    rst_n = 1'b1;

    do_hit(3'd2, 5'd3);

    for (int i = 0; i < 6; i++) do_miss(5'd1, 8'h0F, 0, 1'b0, way_t'(i % 5));

    do_miss(5'd7, 8'hA5, 3, 1'b0, 3'd0);

    do_miss(5'd5, 8'h33, 0, 1'b1, 3'd0);
    do_miss(5'd5, 8'h34, 0, 1'b0, 3'd0);
    do_miss(5'd5, 8'h35, 0, 1'b0, 3'd1);

    m0 = mem_req_cnt;
    lookup(1'b0, 3'd0, 5'd26, 8'h11);
    check_val("oor_resp_valid", 32'(bus.resp_valid), 32'd1);
    check_val("oor_resp_err",   32'(bus.resp_err),   32'd1);
    check_val("oor_resp_hit",   32'(bus.resp_hit),   32'd0);
    check_val("oor_resp_way",   32'(bus.resp_way),   32'd0);
    @(negedge clk);
    #1;
    check_val("oor_no_memreq", 32'(mem_req_cnt), 32'(m0));

    // Set 1 sits at way 1 here; reset in WAIT must drop the transaction and the pointers.
    t0 = tag_we_cnt;
    r0 = resp_cnt;
    lookup(1'b0, 3'd0, 5'd1, 8'h22);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rstw_lk_ready",   32'(bus.lk_ready),   32'd1);
    check_val("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    check_val("rstw_idle", 32'(bus.lk_ready), 32'd1);
    @(negedge clk);
    #1;
    check_val("rstw_no_tagwe", 32'(tag_we_cnt), 32'(t0));
    check_val("rstw_no_resp",  32'(resp_cnt),   32'(r0));
    do_miss(5'd1, 8'h44, 0, 1'b0, 3'd0);
    do_miss(5'd1, 8'h45, 0, 1'b0, 3'd1);

`ifdef CACHE_STATS_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("stat_rst_hits", 32'(hit_count), 32'd0);
    for (int i = 0; i < 3; i++) do_hit(way_t'(i), 5'd2);
    do_miss(5'd9, 8'h01, 0, 1'b0, 3'd0);
    do_miss(5'd9, 8'h02, 0, 1'b0, 3'd1);
    check_val("stat_hits",   32'(hit_count),  32'd3);
    check_val("stat_misses", 32'(miss_count), 32'd2);
    @(negedge clk);
    force dut.hit_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.hit_count_q;
    do_hit(3'd1, 5'd2);
    do_hit(3'd1, 5'd2);
    check_val("stat_hit_sat", 32'(hit_count), 32'h0000FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
